axil_nonce_sweeper: RTL and testbench
=====================================

// Module: axil_nonce_sweeper
// PURPOSE
// AXI4-Lite master that drives the miner register block.
// - Accepts a mining job: 80-byte header, 256-bit target, nonce start and nonce count.
// - Loads the header and target registers, then loops per nonce:
//   write nonce word -> write CONTROL.start -> poll STATUS -> read HASH on found.
// - Reports found nonces plus job completion to the job source (host FIFO / PS-side glue).
// PARAMETERS
// C_M_AXI_ADDR_WIDTH  8        slave address width; byte addresses
// C_M_AXI_DATA_WIDTH  32       data width; only 32 supported
// BASE_ADDR           8'h00    slave base; added to every register offset
// STOP_ON_FOUND       1        1: job ends at first found nonce; 0: sweep full count
// TIMEOUT_POLLS       1024     STATUS reads per nonce before timeout (SWEEP_TIMEOUT_EN only)
// PORTS
// M_AXI_ACLK     in   1    clock; all logic on rising edge
// M_AXI_ARESETN  in   1    async active-low reset
// M_AXI_AWADDR/AWVALID out A/1; M_AXI_AWREADY in 1    write address channel
// M_AXI_WDATA/WSTRB/WVALID out 32/4/1; M_AXI_WREADY in 1    write data channel
// M_AXI_BRESP/BVALID in 2/1; M_AXI_BREADY out 1    write response channel
// M_AXI_ARADDR/ARVALID out A/1; M_AXI_ARREADY in 1    read address channel
// M_AXI_RDATA/RRESP/RVALID in 32/2/1; M_AXI_RREADY out 1    read data channel
// job_valid/job_ready  in/out  1    job handshake; accepted when both high
// job_header     in   640  header; [639:608] = word 0 (big-endian words)
// job_target     in   256  target; [255:224] = TARGET[0]
// job_nonce_start in  32   first nonce (numeric value)
// job_nonce_count in  32   number of nonces to try; 0 = none
// abort          in   1    pulse; stop after the in-flight transaction
// res_valid      out  1    1-cycle pulse per found nonce
// res_nonce      out  32   nonce that met the target
// res_hash       out  256  HASH[0..7]; HASH[0] in [255:224]
// done           out  1    1-cycle pulse at job end
// done_found     out  1    with done: at least one nonce found this job
// err            out  1    sticky until next job accept: SLVERR/DECERR seen or timeout
// BEHAVIOUR
// - Reset values: all VALIDs 0, BREADY 0, RREADY 0, job_ready 1, res_valid 0, done 0,
//   done_found 0, err 0, res_nonce/res_hash 0, addresses/data 0.
// - Async reset mid-transaction abandons the transaction; the slave shares this reset.
// - Bus engine: one outstanding transaction.
//   - Write: AWVALID and WVALID rise together, WSTRB=4'hF. Each drops independently on
//     its own handshake; addr/data held stable until then.
//   - BREADY=1 only after both AW and W have handshaken; B handshake ends the write.
//   - Read: ARVALID until ARREADY. RREADY=1 after the AR handshake; the R handshake
//     captures RDATA.
//   - Non-OKAY BRESP/RRESP: set err, go to DONE.
// - FSM states: IDLE, LD_HDR, LD_TGT, WR_NONCE, WR_START, POLL, RD_HASH, REPORT, NEXT, DONE.
//   - IDLE: job_ready=1. On accept, latch the job and clear err/found.
//     count==0 -> DONE (no bus traffic); else -> LD_HDR.
//   - LD_HDR: header words 0..18 to 0x00..0x48 in ascending order -> LD_TGT.
//   - LD_TGT: target words 0..7 to 0x58..0x74 -> WR_NONCE.
//   - WR_NONCE: 0x4C <= byte-swap(nonce). Header bytes are little-endian;
//     nonce 0x12345678 is written as 0x78563412.
//   - WR_START: 0x50 <= 32'h1 -> POLL.
//   - POLL: read 0x54.
//     - bit2==0: reissue the read next cycle.
//     - bit2==1 and bit3==1: -> RD_HASH.
//     - bit2==1 and bit3==0: -> NEXT.
//     - The slave clears hash_valid on start acceptance; no stale-status guard is needed.
//   - RD_HASH: read 0x78..0x94 into res_hash -> REPORT.
//   - REPORT: res_valid pulse for 1 cycle, set found; STOP_ON_FOUND ? DONE : NEXT.
//   - NEXT: nonce+1 mod 2^32 (0xFFFFFFFF wraps to 0); remaining-1.
//     remaining==0 -> DONE, else -> WR_NONCE.
//   - DONE: done pulse for 1 cycle, done_found=found -> IDLE.
// - abort: latched. Checked only at transaction boundaries; never drops a VALID early.
//   Goes to DONE with done_found reflecting the nonces already found.
// - abort in IDLE is ignored. A job arriving while busy stalls (job_ready=0).
// CONFIGURATION
// - SWEEP_TIMEOUT_EN defined:
//   - Per-nonce poll counter, reset on entering POLL.
//   - TIMEOUT_POLLS STATUS reads with bit2==0 -> set err, go to DONE.
// - SWEEP_TIMEOUT_EN undefined: POLL waits indefinitely; err comes only from bus responses.
// TESTING
// - Bench: this block connected to the miner register slave and a SHA-256 reference model;
//   a monitor checks every AXI transaction.
// - count=1, target all 0xFFFFFFFF, start=0x12345678 -> 19+8 header/target writes;
//   0x4C<=0x78563412; 0x50<=1; polls; 8 hash reads; res_valid with res_nonce=0x12345678;
//   done, done_found=1.
// - STOP_ON_FOUND=0, count=3, target all 1s -> three res_valid with nonces start..start+2;
//   each res_hash equals the model; done_found=1.
// - start=0xFFFFFFFE, count=3, target all 0 -> 0x4C writes FEFFFFFF, FFFFFFFF, 00000000;
//   no res_valid; done with done_found=0.
// - count=0 -> done one cycle after IDLE exit; zero AXI transactions; job_ready back to 1.
// - Slave model holds AWREADY low 5 cycles with WREADY early; BRESP=2'b10 on 3rd target
//   write -> AW/W stable while waiting; no duplicate write; err=1; done; no further traffic.
// - abort during POLL -> current read completes; done next; no new AR issued.
//   With SWEEP_TIMEOUT_EN and hash_valid stuck 0 -> err after 1024 polls.

Source files
------------

// File: rtl/axil_nonce_sweeper_if.sv
// ---------------------------------------------------------------------------
// axil_nonce_sweeper_if
// AXI4-Lite bundle between the nonce sweeper (master) and the miner register
// block (slave).
//   aw*  : write address channel     w* : write data channel
//   b*   : write response channel    ar*: read address channel
//   r*   : read data channel
// Modports: master (sweeper side), slave (register block side).
// ---------------------------------------------------------------------------
interface axil_nonce_sweeper_if #(
    parameter int C_M_AXI_ADDR_WIDTH = 8,
    parameter int C_M_AXI_DATA_WIDTH = 32
);
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic                            awvalid;
    logic                            awready;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wvalid;
    logic                            wready;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr;
    logic                            arvalid;
    logic                            arready;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_nonce_sweeper.sv
// ---------------------------------------------------------------------------
// axil_nonce_sweeper
// AXI4-Lite master that loads a mining job into the miner register block and
// sweeps a nonce range: write nonce, start, poll STATUS, read HASH on a hit.
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN : clock, async active-low reset
//   m_axi                     : AXI4-Lite master (axil_nonce_sweeper_if.master)
//   job_valid/job_ready       : job handshake; job_header/target/nonce_start/count
//   abort                     : pulse, honoured at the next transaction boundary
//   res_valid/res_nonce/res_hash : one pulse per found nonce
//   done/done_found           : job-end pulse, with "anything found" flag
//   err                       : sticky bus-error/timeout flag, cleared on job accept
// Optional feature: define SWEEP_TIMEOUT_EN to bound STATUS polling per nonce
// to TIMEOUT_POLLS reads.
// ---------------------------------------------------------------------------
module axil_nonce_sweeper #(
    parameter int C_M_AXI_ADDR_WIDTH = 8,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter bit STOP_ON_FOUND = 1'b1,
    parameter int TIMEOUT_POLLS = 1024
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESETN,
    axil_nonce_sweeper_if.master  m_axi,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [639:0]          job_header,
    input  logic [255:0]          job_target,
    input  logic [31:0]           job_nonce_start,
    input  logic [31:0]           job_nonce_count,
    input  logic                  abort,
    output logic                  res_valid,
    output logic [31:0]           res_nonce,
    output logic [255:0]          res_hash,
    output logic                  done,
    output logic                  done_found,
    output logic                  err
);
    localparam int A = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [3:0] {
        S_IDLE, S_LD_HDR, S_LD_TGT, S_WR_NONCE, S_WR_START,
        S_POLL, S_RD_HASH, S_REPORT, S_NEXT, S_DONE
    } state_t;

    state_t         state;
    logic [A-1:0]   awaddr_q, araddr_q;
    logic [31:0]    wdata_q;
    logic           awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic           aw_ok, w_ok, pend;
    logic [639:0]   hdr_q;
    logic [255:0]   tgt_q;
    logic [31:0]    nonce_q, remain_q;
    logic [4:0]     idx;
    logic           found_q, abort_q;
`ifdef SWEEP_TIMEOUT_EN
    logic [31:0]    poll_cnt;
`endif

    wire [31:0] unused_cfg = 32'(C_M_AXI_DATA_WIDTH) ^ 32'(TIMEOUT_POLLS);

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    logic aw_hs, w_hs, ar_hs, wr_cpl, rd_cpl, xfer_cpl, xfer_bad, stop_req;
    assign aw_hs    = awvalid_q & m_axi.awready;
    assign w_hs     = wvalid_q & m_axi.wready;
    assign ar_hs    = arvalid_q & m_axi.arready;
    assign wr_cpl   = bready_q & m_axi.bvalid;
    assign rd_cpl   = rready_q & m_axi.rvalid;
    assign xfer_cpl = wr_cpl | rd_cpl;
    assign xfer_bad = (wr_cpl && m_axi.bresp != 2'b00) || (rd_cpl && m_axi.rresp != 2'b00);
    // An abort arriving on the completing cycle is honoured immediately.
    assign stop_req = abort_q | abort;

    // Transaction the current state issues next.
    logic         op_rd;
    logic [A-1:0] op_off;
    logic [31:0]  op_data;
    always_comb begin
        op_rd   = 1'b0;
        op_off  = '0;
        op_data = '0;
        case (state)
            S_LD_HDR:   begin op_off = A'({idx, 2'b00}); op_data = hdr_q[639:608]; end
            S_LD_TGT:   begin op_off = A'(8'h58) + A'({idx, 2'b00}); op_data = tgt_q[255:224]; end
            // Header bytes are little-endian on the slave side.
            S_WR_NONCE: begin
                op_off  = A'(8'h4C);
                op_data = {nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};
            end
            S_WR_START: begin op_off = A'(8'h50); op_data = 32'h1; end
            S_POLL:     begin op_rd = 1'b1; op_off = A'(8'h54); end
            S_RD_HASH:  begin op_rd = 1'b1; op_off = A'(8'h78) + A'({idx, 2'b00}); end
            default:    ;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state      <= S_IDLE;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            wdata_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            aw_ok      <= 1'b0;
            w_ok       <= 1'b0;
            pend       <= 1'b0;
            hdr_q      <= '0;
            tgt_q      <= '0;
            nonce_q    <= '0;
            remain_q   <= '0;
            idx        <= '0;
            found_q    <= 1'b0;
            abort_q    <= 1'b0;
            job_ready  <= 1'b1;
            res_valid  <= 1'b0;
            res_nonce  <= '0;
            res_hash   <= '0;
            done       <= 1'b0;
            done_found <= 1'b0;
            err        <= 1'b0;
`ifdef SWEEP_TIMEOUT_EN
            poll_cnt   <= '0;
`endif
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            if (abort && state != S_IDLE) abort_q <= 1'b1;

            // Channel bookkeeping: AW and W retire independently; B opens once both have.
            if (aw_hs) begin awvalid_q <= 1'b0; aw_ok <= 1'b1; end
            if (w_hs)  begin wvalid_q  <= 1'b0; w_ok  <= 1'b1; end
            if ((aw_ok || aw_hs) && (w_ok || w_hs)) begin
                bready_q <= 1'b1;
                aw_ok    <= 1'b0;
                w_ok     <= 1'b0;
            end
            if (wr_cpl) bready_q <= 1'b0;
            if (ar_hs) begin arvalid_q <= 1'b0; rready_q <= 1'b1; end
            if (rd_cpl) rready_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (job_valid && job_ready) begin
                        job_ready <= 1'b0;
                        hdr_q     <= job_header;
                        tgt_q     <= job_target;
                        nonce_q   <= job_nonce_start;
                        remain_q  <= job_nonce_count;
                        idx       <= '0;
                        err       <= 1'b0;
                        found_q   <= 1'b0;
                        abort_q   <= 1'b0;
                        pend      <= 1'b0;
                        state     <= (job_nonce_count == 32'd0) ? S_DONE : S_LD_HDR;
                    end
                end
                S_LD_HDR, S_LD_TGT, S_WR_NONCE, S_WR_START, S_POLL, S_RD_HASH: begin
                    if (!pend) begin
                        // Abort is only honoured between transactions.
                        if (stop_req) begin
                            state <= S_DONE;
                        end else begin
                            pend <= 1'b1;
                            if (op_rd) begin
                                arvalid_q <= 1'b1;
                                araddr_q  <= BASE_ADDR + op_off;
                            end else begin
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                awaddr_q  <= BASE_ADDR + op_off;
                                wdata_q   <= op_data;
                            end
                        end
                    end else if (xfer_cpl) begin
                        pend <= 1'b0;
                        if (xfer_bad) begin
                            err   <= 1'b1;
                            state <= S_DONE;
                        end else if (stop_req) begin
                            state <= S_DONE;
                        end else begin
                            case (state)
                                S_LD_HDR: begin
                                    hdr_q <= {hdr_q[607:0], 32'h0};
                                    idx   <= (idx == 5'd18) ? 5'd0 : idx + 5'd1;
                                    if (idx == 5'd18) state <= S_LD_TGT;
                                end
                                S_LD_TGT: begin
                                    tgt_q <= {tgt_q[223:0], 32'h0};
                                    idx   <= (idx == 5'd7) ? 5'd0 : idx + 5'd1;
                                    if (idx == 5'd7) state <= S_WR_NONCE;
                                end
                                S_WR_NONCE: state <= S_WR_START;
                                S_WR_START: begin
                                    state <= S_POLL;
`ifdef SWEEP_TIMEOUT_EN
                                    poll_cnt <= '0;
`endif
                                end
                                S_POLL: begin
                                    if (m_axi.rdata[2]) begin
                                        idx   <= '0;
                                        state <= m_axi.rdata[3] ? S_RD_HASH : S_NEXT;
                                    end else begin
`ifdef SWEEP_TIMEOUT_EN
                                        if (poll_cnt == 32'(TIMEOUT_POLLS - 1)) begin
                                            err   <= 1'b1;
                                            state <= S_DONE;
                                        end else begin
                                            poll_cnt <= poll_cnt + 32'd1;
                                        end
`endif
                                    end
                                end
                                S_RD_HASH: begin
                                    // HASH[0] ends up in the top word after eight shifts.
                                    res_hash <= {res_hash[223:0], m_axi.rdata};
                                    idx      <= idx + 5'd1;
                                    if (idx == 5'd7) state <= S_REPORT;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_REPORT: begin
                    res_valid <= 1'b1;
                    res_nonce <= nonce_q;
                    found_q   <= 1'b1;
                    state     <= STOP_ON_FOUND ? S_DONE : S_NEXT;
                end
                S_NEXT: begin
                    nonce_q  <= nonce_q + 32'd1;
                    remain_q <= remain_q - 32'd1;
                    state    <= (remain_q == 32'd1) ? S_DONE : S_WR_NONCE;
                end
                S_DONE: begin
                    done       <= 1'b1;
                    done_found <= found_q;
                    job_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_nonce_sweeper.sv
// ---------------------------------------------------------------------------
// tb_axil_nonce_sweeper
// Directed bench: a behavioural register-block slave (write log, STATUS with a
// short busy period, synthetic HASH derived from the stored nonce) plus a
// channel-stability monitor, driven by one task per scenario.
// ---------------------------------------------------------------------------
module tb_axil_nonce_sweeper;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axil_nonce_sweeper_if #(.C_M_AXI_ADDR_WIDTH(8), .C_M_AXI_DATA_WIDTH(32)) bus ();

    logic         job_valid = 1'b0, job_ready, abort = 1'b0;
    logic [639:0] job_header = '0;
    logic [255:0] job_target = '0;
    logic [31:0]  job_nonce_start = '0, job_nonce_count = '0;
    logic         res_valid, done, done_found, err;
    logic [31:0]  res_nonce;
    logic [255:0] res_hash;

    axil_nonce_sweeper #(
        .C_M_AXI_ADDR_WIDTH(8), .C_M_AXI_DATA_WIDTH(32), .BASE_ADDR(8'h00),
        .STOP_ON_FOUND(1'b0), .TIMEOUT_POLLS(1024)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .m_axi(bus),
        .job_valid(job_valid), .job_ready(job_ready), .job_header(job_header),
        .job_target(job_target), .job_nonce_start(job_nonce_start),
        .job_nonce_count(job_nonce_count), .abort(abort),
        .res_valid(res_valid), .res_nonce(res_nonce), .res_hash(res_hash),
        .done(done), .done_found(done_found), .err(err)
    );

    int n_checks = 0;
    int n_fail = 0;

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // Synthetic hash the slave model returns for a given nonce.
    function automatic logic [31:0] hfn(input logic [31:0] n, input int i);
        return {n[15:0], n[31:16]} ^ (32'h9E3779B9 * 32'(i + 1));
    endfunction

    function automatic logic [255:0] exp_hash(input logic [31:0] n);
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[255-32*i -: 32] = hfn(n, i);
        return h;
    endfunction

    // ---------------- slave model ----------------
    logic [31:0] mem [0:63];
    int   aw_delay = 0, aw_cnt = 0, err_at = -1, poll_left = 0, ar_num = 0, st_num = 0;
    bit   stuck = 1'b0, got_aw = 1'b0, got_w = 1'b0;
    logic [7:0]  waddr, ra;
    logic [31:0] wdat;
    logic [7:0]  wlog_a [$];
    logic [31:0] wlog_d [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.awready <= 1'b0; bus.wready <= 1'b0; bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
            bus.arready <= 1'b0; bus.rvalid <= 1'b0; bus.rdata <= '0; bus.rresp <= 2'b00;
            got_aw <= 1'b0; got_w <= 1'b0; aw_cnt <= 0; poll_left <= 0;
        end else begin
            if (bus.awvalid && !bus.awready) begin
                if (aw_cnt >= aw_delay) bus.awready <= 1'b1;
                else aw_cnt <= aw_cnt + 1;
            end
            if (bus.awvalid && bus.awready) begin
                bus.awready <= 1'b0; aw_cnt <= 0; got_aw <= 1'b1; waddr <= bus.awaddr;
            end
            if (bus.wvalid && !bus.wready) bus.wready <= 1'b1;
            if (bus.wvalid && bus.wready) begin
                bus.wready <= 1'b0; got_w <= 1'b1; wdat <= bus.wdata;
            end
            if (got_aw && got_w && !bus.bvalid) begin
                got_aw <= 1'b0; got_w <= 1'b0;
                mem[waddr[7:2]] <= wdat;
                bus.bresp  <= (wlog_a.size() == err_at) ? 2'b10 : 2'b00;
                bus.bvalid <= 1'b1;
                wlog_a.push_back(waddr);
                wlog_d.push_back(wdat);
                if (waddr == 8'h50 && wdat == 32'h1) poll_left <= 2;
            end
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;

            if (bus.arvalid && !bus.arready) bus.arready <= 1'b1;
            if (bus.arvalid && bus.arready) begin
                ra = bus.araddr;
                bus.arready <= 1'b0; bus.rvalid <= 1'b1; bus.rresp <= 2'b00;
                ar_num <= ar_num + 1;
                if (ra == 8'h54) begin
                    st_num <= st_num + 1;
                    if (stuck || poll_left > 0) begin
                        bus.rdata <= 32'h0;
                        if (poll_left > 0) poll_left <= poll_left - 1;
                    end else begin
                        bus.rdata <= {28'd0, (mem[22] == 32'hFFFFFFFF), 1'b1, 2'b00};
                    end
                end else if (ra >= 8'h78 && ra <= 8'h94) begin
                    bus.rdata <= hfn(bswap(mem[19]), int'((ra - 8'h78) >> 2));
                end else begin
                    bus.rdata <= mem[ra[7:2]];
                end
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
        end
    end

    // ---------------- channel monitor ----------------
    int   stab_err = 0;
    logic p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
    logic [7:0]  p_awa, p_ara;
    logic [31:0] p_wd;
    always @(posedge clk) begin
        if (rst_n) begin
            if (p_awv && !p_awr && (!bus.awvalid || bus.awaddr != p_awa)) stab_err++;
            if (p_wv && !p_wr && (!bus.wvalid || bus.wdata != p_wd)) stab_err++;
            if (p_arv && !p_arr && (!bus.arvalid || bus.araddr != p_ara)) stab_err++;
            if (bus.bready && (bus.awvalid || bus.wvalid)) stab_err++;
            if (bus.wvalid && bus.wstrb != 4'hF) stab_err++;
        end
        p_awv <= bus.awvalid; p_awr <= bus.awready; p_awa <= bus.awaddr;
        p_wv  <= bus.wvalid;  p_wr  <= bus.wready;  p_wd  <= bus.wdata;
        p_arv <= bus.arvalid; p_arr <= bus.arready; p_ara <= bus.araddr;
    end

    logic [31:0]  res_n [$];
    logic [255:0] res_h [$];
    always @(negedge clk) begin
        if (res_valid) begin
            res_n.push_back(res_nonce);
            res_h.push_back(res_hash);
        end
    end

    // ---------------- job driver ----------------
    task automatic start_job(input logic [31:0] start, input logic [31:0] count,
                             input bit ones, output bit acc);
        for (int i = 0; i < 19; i++) job_header[639-32*i -: 32] = 32'hA0000000 | 32'(i);
        job_header[31:0] = 32'hDEADBEEF;
        job_target      = ones ? {256{1'b1}} : '0;
        job_nonce_start = start;
        job_nonce_count = count;
        wlog_a.delete(); wlog_d.delete(); res_n.delete(); res_h.delete();
        @(negedge clk);
        job_valid = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            if (job_ready) begin acc = 1'b1; break; end
        end
        #1 job_valid = 1'b0;
    endtask

    task automatic wait_done(output bit got, output logic df, output logic e, output int cyc);
        got = 1'b0; df = 1'b0; e = 1'b0; cyc = 0;
        for (int c = 1; c <= 4000; c++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; df = done_found; e = err; cyc = c; break; end
        end
    endtask

    task automatic run_job(input logic [31:0] start, input logic [31:0] count, input bit ones,
                           output bit got, output logic df, output logic e, output int cyc);
        bit acc;
        start_job(start, count, ones, acc);
        got = 1'b0; df = 1'b0; e = 1'b0; cyc = 0;
        if (acc) wait_done(got, df, e, cyc);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_job_ready: got %b expected 1", job_ready); end
        n_checks++; if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
            n_fail++; $display("FAIL reset_bus_ctrl: got %b expected 00000", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}); end
        n_checks++; if ({res_valid, done, done_found, err} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {res_valid, done, done_found, err}); end
        n_checks++; if (res_nonce !== 32'h0 || res_hash !== 256'h0) begin
            n_fail++; $display("FAIL reset_results: got %h/%h expected 0", res_nonce, res_hash); end
        n_checks++; if (bus.awaddr !== 8'h0 || bus.wdata !== 32'h0 || bus.araddr !== 8'h0) begin
            n_fail++; $display("FAIL reset_addr_data: got %h %h %h expected 0", bus.awaddr, bus.wdata, bus.araddr); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        bit got; logic df, e; int cyc;
        run_job(32'h12345678, 32'd1, 1'b1, got, df, e, cyc);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b expected 1", got); end
        n_checks++; if (df !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL single_flags: got found=%b err=%b expected 1/0", df, e); end
        n_checks++; if (wlog_a.size() != 29) begin n_fail++; $display("FAIL single_wr_count: got %0d expected 29", wlog_a.size()); end
        if (wlog_a.size() == 29) begin
            for (int i = 0; i < 19; i++) begin
                n_checks++;
                if (wlog_a[i] !== 8'(4*i) || wlog_d[i] !== (32'hA0000000 | 32'(i))) begin
                    n_fail++; $display("FAIL single_hdr%0d: got %h<=%h expected %h<=%h", i, wlog_a[i], wlog_d[i], 8'(4*i), 32'hA0000000 | 32'(i)); end
            end
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (wlog_a[19+i] !== 8'(8'h58 + 4*i) || wlog_d[19+i] !== 32'hFFFFFFFF) begin
                    n_fail++; $display("FAIL single_tgt%0d: got %h<=%h expected %h<=ffffffff", i, wlog_a[19+i], wlog_d[19+i], 8'(8'h58 + 4*i)); end
            end
            n_checks++; if (wlog_a[27] !== 8'h4C || wlog_d[27] !== 32'h78563412) begin
                n_fail++; $display("FAIL single_nonce_wr: got %h<=%h expected 4c<=78563412", wlog_a[27], wlog_d[27]); end
            n_checks++; if (wlog_a[28] !== 8'h50 || wlog_d[28] !== 32'h1) begin
                n_fail++; $display("FAIL single_start_wr: got %h<=%h expected 50<=00000001", wlog_a[28], wlog_d[28]); end
        end
        n_checks++; if (res_n.size() != 1) begin n_fail++; $display("FAIL single_res_count: got %0d expected 1", res_n.size()); end
        else begin
            n_checks++; if (res_n[0] !== 32'h12345678) begin n_fail++; $display("FAIL single_res_nonce: got %h expected 12345678", res_n[0]); end
            n_checks++; if (res_h[0] !== exp_hash(32'h12345678)) begin
                n_fail++; $display("FAIL single_res_hash: got %h expected %h", res_h[0], exp_hash(32'h12345678)); end
        end
        n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL single_stability: got %0d violations expected 0", stab_err); end
    endtask

    task automatic test_sweep();
        bit got; logic df, e; int cyc;
        logic [31:0] nw [$];
        logic [31:0] exp_w [3] = '{32'hFF000000, 32'h00010000, 32'h01010000};
        logic [31:0] exp_n [3] = '{32'h000000FF, 32'h00000100, 32'h00000101};
        run_job(32'h000000FF, 32'd3, 1'b1, got, df, e, cyc);
        for (int i = 0; i < wlog_a.size(); i++) if (wlog_a[i] == 8'h4C) nw.push_back(wlog_d[i]);
        n_checks++; if (got !== 1'b1 || df !== 1'b1 || e !== 1'b0) begin
            n_fail++; $display("FAIL sweep_done: got done=%b found=%b err=%b expected 1/1/0", got, df, e); end
        n_checks++; if (wlog_a.size() != 33 || nw.size() != 3) begin
            n_fail++; $display("FAIL sweep_wr_count: got %0d/%0d expected 33/3", wlog_a.size(), nw.size()); end
        n_checks++; if (res_n.size() != 3) begin n_fail++; $display("FAIL sweep_res_count: got %0d expected 3", res_n.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < nw.size()) begin
                n_checks++; if (nw[i] !== exp_w[i]) begin n_fail++; $display("FAIL sweep_nonce_wr%0d: got %h expected %h", i, nw[i], exp_w[i]); end
            end
            if (i < res_n.size()) begin
                n_checks++; if (res_n[i] !== exp_n[i] || res_h[i] !== exp_hash(exp_n[i])) begin
                    n_fail++; $display("FAIL sweep_res%0d: got %h/%h expected %h/%h", i, res_n[i], res_h[i], exp_n[i], exp_hash(exp_n[i])); end
            end
        end
    endtask

    task automatic test_wrap();
        bit got; logic df, e; int cyc;
        logic [31:0] nw [$];
        logic [31:0] exp_w [3] = '{32'hFEFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        run_job(32'hFFFFFFFE, 32'd3, 1'b0, got, df, e, cyc);
        for (int i = 0; i < wlog_a.size(); i++) if (wlog_a[i] == 8'h4C) nw.push_back(wlog_d[i]);
        n_checks++; if (got !== 1'b1 || df !== 1'b0 || e !== 1'b0) begin
            n_fail++; $display("FAIL wrap_done: got done=%b found=%b err=%b expected 1/0/0", got, df, e); end
        n_checks++; if (res_n.size() != 0) begin n_fail++; $display("FAIL wrap_res_count: got %0d expected 0", res_n.size()); end
        n_checks++; if (nw.size() != 3) begin n_fail++; $display("FAIL wrap_nonce_count: got %0d expected 3", nw.size()); end
        for (int i = 0; i < 3 && i < nw.size(); i++) begin
            n_checks++; if (nw[i] !== exp_w[i]) begin n_fail++; $display("FAIL wrap_nonce_wr%0d: got %h expected %h", i, nw[i], exp_w[i]); end
        end
    endtask

    task automatic test_zero_count();
        bit got; logic df, e; int cyc; int ar0;
        ar0 = ar_num;
        run_job(32'h00000005, 32'd0, 1'b1, got, df, e, cyc);
        n_checks++; if (got !== 1'b1 || cyc != 2) begin n_fail++; $display("FAIL zero_done_latency: got done=%b cycles=%0d expected 1/2", got, cyc); end
        n_checks++; if (wlog_a.size() != 0 || ar_num != ar0) begin
            n_fail++; $display("FAIL zero_traffic: got %0d writes %0d reads expected 0/0", wlog_a.size(), ar_num - ar0); end
        n_checks++; if (job_ready !== 1'b1 || df !== 1'b0) begin
            n_fail++; $display("FAIL zero_ready: got ready=%b found=%b expected 1/0", job_ready, df); end
    endtask

    task automatic test_bresp_err();
        bit got; logic df, e; int cyc; int ar0;
        ar0 = ar_num; stab_err = 0;
        aw_delay = 5; err_at = 21;
        run_job(32'h00000001, 32'd1, 1'b1, got, df, e, cyc);
        repeat (10) @(negedge clk);
        n_checks++; if (got !== 1'b1 || e !== 1'b1 || df !== 1'b0) begin
            n_fail++; $display("FAIL berr_done: got done=%b err=%b found=%b expected 1/1/0", got, e, df); end
        n_checks++; if (wlog_a.size() != 22 || ar_num != ar0) begin
            n_fail++; $display("FAIL berr_traffic: got %0d writes %0d reads expected 22/0", wlog_a.size(), ar_num - ar0); end
        if (wlog_a.size() == 22) begin
            n_checks++; if (wlog_a[21] !== 8'h60) begin n_fail++; $display("FAIL berr_last_addr: got %h expected 60", wlog_a[21]); end
        end
        n_checks++; if (stab_err != 0 || bus.awvalid !== 1'b0 || err !== 1'b1) begin
            n_fail++; $display("FAIL berr_hold: got viol=%0d awvalid=%b err=%b expected 0/0/1", stab_err, bus.awvalid, err); end
        aw_delay = 0; err_at = -1;
    endtask

    task automatic test_abort();
        bit acc, got, hit; logic df, e; int cyc; int ar_snap;
        stuck = 1'b1; hit = 1'b0;
        start_job(32'h00000010, 32'd5, 1'b1, acc);
        for (int c = 0; c < 3000 && acc; c++) begin
            @(negedge clk);
            if (bus.rvalid && st_num >= 3) begin hit = 1'b1; break; end
        end
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL abort_reach_poll: got %b expected 1", hit); end
        ar_snap = ar_num;
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_done(got, df, e, cyc);
        n_checks++; if (got !== 1'b1 || cyc > 3) begin n_fail++; $display("FAIL abort_done: got done=%b cycles=%0d expected 1/<=3", got, cyc); end
        n_checks++; if (df !== 1'b0 || e !== 1'b0) begin n_fail++; $display("FAIL abort_flags: got found=%b err=%b expected 0/0", df, e); end
        repeat (20) @(negedge clk);
        n_checks++; if (ar_num != ar_snap || bus.arvalid !== 1'b0 || wlog_a.size() != 29) begin
            n_fail++; $display("FAIL abort_no_new_ar: got %0d new reads arvalid=%b writes=%0d expected 0/0/29", ar_num - ar_snap, bus.arvalid, wlog_a.size()); end
        stuck = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_wrap();
        test_zero_count();
        test_bresp_err();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
